// File: rtl/emb_grad_accum_if.sv
`default_nettype none
// ============================================================================
//  Module   : emb_grad_accum_if
//  Purpose  : Bundles the request handshake and the gradient-RAM port of
//             emb_grad_accum.
//             slave  - seen by the accumulator
//             master - seen by the requester / RAM model
//  Signals  : start, mode, d_forward, d_backward  (request)
//             busy, done, skip_cnt                 (status)
//             re, raddr, rdata                     (RAM read port, 1-cycle latency)
//             we, waddr, wdata                     (RAM write port)
//  Revision : 1.0  initial release
// ============================================================================
interface emb_grad_accum_if #(
    parameter int TOKENS     = 10,
    parameter int CHAR_W     = 8,
    parameter int EMB_DIM    = 24,
    parameter int LANES      = 8,
    parameter int GRAD_W     = 16,
    parameter int ACC_W      = 16,
    parameter int ADDR_WIDTH = 10
);
    logic                             start;
    logic                             mode;
    logic [TOKENS*CHAR_W-1:0]         d_forward;
    logic [TOKENS*EMB_DIM*GRAD_W-1:0] d_backward;
    logic                             busy;
    logic                             done;
    logic [CHAR_W-1:0]                skip_cnt;
    logic                             re;
    logic [ADDR_WIDTH-1:0]            raddr;
    logic [LANES*ACC_W-1:0]           rdata;
    logic                             we;
    logic [ADDR_WIDTH-1:0]            waddr;
    logic [LANES*ACC_W-1:0]           wdata;

    modport slave (
        input  start, mode, d_forward, d_backward, rdata,
        output busy, done, skip_cnt, re, raddr, we, waddr, wdata
    );

    modport master (
        output start, mode, d_forward, d_backward, rdata,
        input  busy, done, skip_cnt, re, raddr, we, waddr, wdata
    );
endinterface
`default_nettype wire

// File: rtl/emb_grad_accum.sv
`default_nettype none
// ============================================================================
//  Module   : emb_grad_accum
//  Purpose  : Scatters a batch of per-token gradient rows into the embedding
//             weight-gradient RAM by read-modify-write, one word per cycle,
//             with saturating lane arithmetic, forwarding of in-flight writes
//             for repeated rows, out-of-range token skipping and a clear mode.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous active-high reset
//             bus  - emb_grad_accum_if.slave (request, status, RAM ports)
//  Revision : 1.0  initial release
// ============================================================================
module emb_grad_accum #(
    parameter int TOKENS     = 10,
    parameter int CHAR_NUM   = 200,
    parameter int CHAR_W     = 8,
    parameter int EMB_DIM    = 24,
    parameter int LANES      = 8,
    parameter int GRAD_W     = 16,
    parameter int ACC_W      = 16,
    parameter int ADDR_WIDTH = 10
) (
    input wire clk,
    input wire rst,
    emb_grad_accum_if.slave bus
);
    localparam int WPR       = EMB_DIM / LANES;
    localparam int CLR_WORDS = CHAR_NUM * WPR;
    localparam int TOK_W     = (TOKENS > 1) ? $clog2(TOKENS) : 1;
    localparam int WRD_W     = (WPR > 1) ? $clog2(WPR) : 1;
    localparam logic [WRD_W-1:0]      LAST_WORD = WRD_W'(WPR - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_CLR  = ADDR_WIDTH'(CLR_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_CLEAR = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t r_state, w_state_next;

    logic [TOKENS*CHAR_W-1:0]         r_idx;
    logic [TOKENS*EMB_DIM*GRAD_W-1:0] r_grad;
    logic [TOK_W-1:0]                 r_tok;
    logic [WRD_W-1:0]                 r_word;
    logic [CHAR_W-1:0]                r_skip;
    // Stage 1: read data arrives, sum is formed
    logic                             r_s1_valid;
    logic [ADDR_WIDTH-1:0]            r_s1_addr;
    logic [LANES*GRAD_W-1:0]          r_s1_grad;
    // Stage 2: write port registers
    logic                             r_we;
    logic [ADDR_WIDTH-1:0]            r_waddr;
    logic [LANES*ACC_W-1:0]           r_wdata;
    // Previous write, still needed because the RAM returns old data on a
    // same-cycle read/write collision
    logic                             r_w2_we;
    logic [ADDR_WIDTH-1:0]            r_w2_addr;
    logic [LANES*ACC_W-1:0]           r_w2_data;

    logic [TOK_W-1:0]        w_first_tok, w_next_tok;
    logic                    w_any_valid, w_has_next;
    logic [CHAR_W-1:0]       w_skip_in;
    logic [CHAR_W-1:0]       w_cur_idx;
    logic                    w_drained, w_accept, w_busy, w_done, w_re;
    logic [ADDR_WIDTH-1:0]   w_raddr;
    logic [LANES*GRAD_W-1:0] w_grad_word;
    logic [LANES*ACC_W-1:0]  w_base, w_sum;

    // First in-range token of the incoming batch and count of skipped ones
    always_comb begin
        w_first_tok = '0;
        w_any_valid = 1'b0;
        w_skip_in   = '0;
        for (int t = TOKENS - 1; t >= 0; t--) begin
            if (int'(bus.d_forward[t*CHAR_W +: CHAR_W]) < CHAR_NUM) begin
                w_first_tok = TOK_W'(t);
                w_any_valid = 1'b1;
            end else begin
                w_skip_in = w_skip_in + CHAR_W'(1);
            end
        end
    end

    // Next in-range token after the current one; skipped tokens cost no cycle
    always_comb begin
        w_next_tok = '0;
        w_has_next = 1'b0;
        for (int t = TOKENS - 1; t >= 0; t--) begin
            if (t > int'(r_tok) && int'(r_idx[t*CHAR_W +: CHAR_W]) < CHAR_NUM) begin
                w_next_tok = TOK_W'(t);
                w_has_next = 1'b1;
            end
        end
    end

    assign w_cur_idx   = r_idx[int'(r_tok)*CHAR_W +: CHAR_W];
    assign w_raddr     = (r_state == S_ACC) ? ADDR_WIDTH'(int'(w_cur_idx) * WPR + int'(r_word)) : '0;
    assign w_grad_word = r_grad[(int'(r_tok)*EMB_DIM + int'(r_word)*LANES)*GRAD_W +: LANES*GRAD_W];
    assign w_drained   = !r_s1_valid && !r_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // A drained DRAIN cycle is the done cycle and already accepts a new start
    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        w_busy       = 1'b1;
        w_re         = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy   = 1'b0;
                w_accept = bus.start;
            end
            S_ACC: begin
                w_re = 1'b1;
                if (r_word == LAST_WORD && !w_has_next) w_state_next = S_DRAIN;
            end
            S_CLEAR: begin
                if (r_waddr == LAST_CLR) w_state_next = S_DRAIN;
            end
            default: begin
                if (w_drained) begin
                    w_done       = 1'b1;
                    w_busy       = 1'b0;
                    w_accept     = bus.start;
                    w_state_next = S_IDLE;
                end
            end
        endcase
        if (w_accept) begin
            if (bus.mode)         w_state_next = S_CLEAR;
            else if (w_any_valid) w_state_next = S_ACC;
            else                  w_state_next = S_DRAIN;
        end
    end

    // Youngest in-flight write to the same word wins over RAM data
    assign w_base = (r_we && r_waddr == r_s1_addr)       ? r_wdata   :
                    (r_w2_we && r_w2_addr == r_s1_addr) ? r_w2_data : bus.rdata;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [ACC_W-1:0] w_b;
        logic [ACC_W:0]   w_s;
        assign w_b = w_base[l*ACC_W +: ACC_W];
        assign w_s = {w_b[ACC_W-1], w_b}
                   + {{(ACC_W+1-GRAD_W){r_s1_grad[l*GRAD_W+GRAD_W-1]}}, r_s1_grad[l*GRAD_W +: GRAD_W]};
        // Top two bits differ only on overflow; clamp toward the sign of w_s
        assign w_sum[l*ACC_W +: ACC_W] = (w_s[ACC_W] == w_s[ACC_W-1]) ? w_s[ACC_W-1:0]
                                       : {w_s[ACC_W], {(ACC_W-1){~w_s[ACC_W]}}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_grad     <= '0;
            r_tok      <= '0;
            r_word     <= '0;
            r_skip     <= '0;
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_grad  <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_w2_we    <= 1'b0;
            r_w2_addr  <= '0;
            r_w2_data  <= '0;
        end else begin
            if (w_accept) begin
                r_idx  <= bus.d_forward;
                r_grad <= bus.d_backward;
                r_tok  <= w_first_tok;
                r_word <= '0;
                r_skip <= bus.mode ? '0 : w_skip_in;
            end else if (r_state == S_ACC) begin
                if (r_word == LAST_WORD) begin
                    r_word <= '0;
                    r_tok  <= w_next_tok;
                end else begin
                    r_word <= r_word + WRD_W'(1);
                end
            end

            r_s1_valid <= w_re;
            r_s1_addr  <= w_raddr;
            r_s1_grad  <= w_grad_word;

            r_w2_we   <= r_we;
            r_w2_addr <= r_waddr;
            r_w2_data <= r_wdata;

            if (w_accept && bus.mode) begin
                r_we    <= 1'b1;
                r_waddr <= '0;
                r_wdata <= '0;
            end else if (r_state == S_CLEAR) begin
                r_wdata <= '0;
                if (r_waddr == LAST_CLR) begin
                    r_we <= 1'b0;
                end else begin
                    r_we    <= 1'b1;
                    r_waddr <= r_waddr + ADDR_WIDTH'(1);
                end
            end else begin
                r_we <= r_s1_valid;
                if (r_s1_valid) begin
                    r_waddr <= r_s1_addr;
                    r_wdata <= w_sum;
                end
            end
        end
    end

    assign bus.busy     = w_busy;
    assign bus.done     = w_done;
    assign bus.skip_cnt = r_skip;
    assign bus.re       = w_re;
    assign bus.raddr    = w_raddr;
    assign bus.we       = r_we;
    assign bus.waddr    = r_waddr;
    assign bus.wdata    = r_wdata;
endmodule
`default_nettype wire

// File: tb/tb_emb_grad_accum.sv
`default_nettype none
// ============================================================================
//  Module   : tb_emb_grad_accum
//  Purpose  : Directed self-checking bench for emb_grad_accum. u_a uses
//             WPR=2 (EMB_DIM=8, LANES=4), u_b uses WPR=1 (EMB_DIM=4,
//             LANES=4); both have TOKENS=4, CHAR_NUM=200. Each has a
//             behavioural RAM with 1-cycle read latency and read-before-write.
//  Revision : 1.0  initial release
// ============================================================================
module tb_emb_grad_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    emb_grad_accum_if #(.TOKENS(4), .CHAR_W(8), .EMB_DIM(8), .LANES(4),
                        .GRAD_W(16), .ACC_W(16), .ADDR_WIDTH(10)) ifa ();
    emb_grad_accum_if #(.TOKENS(4), .CHAR_W(8), .EMB_DIM(4), .LANES(4),
                        .GRAD_W(16), .ACC_W(16), .ADDR_WIDTH(10)) ifb ();

    emb_grad_accum #(.TOKENS(4), .CHAR_NUM(200), .CHAR_W(8), .EMB_DIM(8), .LANES(4),
                     .GRAD_W(16), .ACC_W(16), .ADDR_WIDTH(10))
        u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    emb_grad_accum #(.TOKENS(4), .CHAR_NUM(200), .CHAR_W(8), .EMB_DIM(4), .LANES(4),
                     .GRAD_W(16), .ACC_W(16), .ADDR_WIDTH(10))
        u_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    logic [63:0] mem_a [0:1023];
    logic [63:0] mem_b [0:1023];
    logic        fill_a = 1'b0, fill_b = 1'b0;
    logic [63:0] fill_val_a = '0, fill_val_b = '0;

    always @(posedge clk) begin
        if (fill_a) begin
            for (int i = 0; i < 1024; i++) mem_a[i] <= fill_val_a;
        end else if (ifa.we) begin
            mem_a[ifa.waddr] <= ifa.wdata;
        end
        if (ifa.re) ifa.rdata <= mem_a[ifa.raddr];
    end

    always @(posedge clk) begin
        if (fill_b) begin
            for (int i = 0; i < 1024; i++) mem_b[i] <= fill_val_b;
        end else if (ifb.we) begin
            mem_b[ifb.waddr] <= ifb.wdata;
        end
        if (ifb.re) ifb.rdata <= mem_b[ifb.raddr];
    end

    int n_err = 0;
    int n_checks = 0;
    int ra_done, ra_nre, ra_nwe, ra_ndone, ra_seq_bad;
    logic ra_busy1;
    int rb_done, rb_nwe;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_mem_a(input logic [63:0] v);
        @(negedge clk); fill_a = 1'b1; fill_val_a = v;
        @(negedge clk); fill_a = 1'b0;
    endtask

    task automatic fill_mem_b(input logic [63:0] v);
        @(negedge clk); fill_b = 1'b1; fill_val_b = v;
        @(negedge clk); fill_b = 1'b0;
    endtask

    // Cycle n is the period after the n-th rising edge following acceptance.
    task automatic run_a(input logic m, input logic [31:0] fwd, input logic [511:0] bwd,
                         input int pulse_at, input int budget);
        ra_done = 0; ra_nre = 0; ra_nwe = 0; ra_ndone = 0; ra_seq_bad = 0;
        @(negedge clk);
        ifa.start = 1'b1; ifa.mode = m; ifa.d_forward = fwd; ifa.d_backward = bwd;
        @(negedge clk);
        ifa.start = 1'b0; ifa.d_forward = ~fwd; ifa.d_backward = ~bwd;
        ra_busy1 = ifa.busy;
        for (int n = 1; n <= budget; n++) begin
            if (ifa.re) ra_nre++;
            if (ifa.we) begin
                if (int'(ifa.waddr) != ra_nwe) ra_seq_bad++;
                ra_nwe++;
            end
            if (ifa.done) begin
                ra_ndone++;
                if (ra_done == 0) ra_done = n;
            end
            ifa.start = (n == pulse_at);
            if (ra_done != 0 && n >= ra_done + 6) break;
            @(negedge clk);
        end
        ifa.start = 1'b0;
    endtask

    task automatic run_b(input logic [31:0] fwd, input logic [255:0] bwd, input int budget);
        rb_done = 0; rb_nwe = 0;
        @(negedge clk);
        ifb.start = 1'b1; ifb.mode = 1'b0; ifb.d_forward = fwd; ifb.d_backward = bwd;
        @(negedge clk);
        ifb.start = 1'b0; ifb.d_forward = ~fwd; ifb.d_backward = ~bwd;
        for (int n = 1; n <= budget; n++) begin
            if (ifb.we) rb_nwe++;
            if (ifb.done && rb_done == 0) rb_done = n;
            if (rb_done != 0 && n >= rb_done + 4) break;
            @(negedge clk);
        end
    endtask

    function automatic logic [63:0] rep(input logic [15:0] v);
        return {4{v}};
    endfunction

    localparam logic [31:0] FWD_DIST = {8'd5, 8'd0, 8'd7, 8'd3};
    logic [511:0] bwd_a;
    logic [255:0] bwd_b;
    int cnt;
    int dist_addr [8] = '{6, 7, 14, 15, 0, 1, 10, 11};

    initial begin
        ifa.start = 0; ifa.mode = 0; ifa.d_forward = '0; ifa.d_backward = '0;
        ifb.start = 0; ifb.mode = 0; ifb.d_forward = '0; ifb.d_backward = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("reset_ctl", {ifa.busy, ifa.done, ifa.re, ifa.we}, 0);
        chk("reset_raddr", ifa.raddr, 0);
        chk("reset_waddr", ifa.waddr, 0);
        chk("reset_wdata", ifa.wdata, 0);
        chk("reset_skip", ifa.skip_cnt, 0);

        // Distinct indices, RAM = 1, grads 2
        fill_mem_a(rep(16'd1));
        run_a(1'b0, FWD_DIST, {32{16'd2}}, 0, 40);
        chk("dist_busy1", ra_busy1, 1);
        chk("dist_done_cyc", ra_done, 11);
        chk("dist_nre", ra_nre, 8);
        chk("dist_nwe", ra_nwe, 8);
        chk("dist_skip", ifa.skip_cnt, 0);
        for (int i = 0; i < 8; i++) chk($sformatf("dist_mem%0d", dist_addr[i]), mem_a[dist_addr[i]], rep(16'd3));
        chk("dist_untouched", mem_a[2], rep(16'd1));

        // Out-of-range tokens
        fill_mem_a(64'd0);
        run_a(1'b0, {8'd0, 8'd255, 8'd200, 8'd199}, {32{16'd5}}, 0, 40);
        chk("oor_done_cyc", ra_done, 7);
        chk("oor_nwe", ra_nwe, 4);
        chk("oor_skip", ifa.skip_cnt, 2);
        chk("oor_mem398", mem_a[398], rep(16'd5));
        chk("oor_mem1", mem_a[1], rep(16'd5));
        chk("oor_mem400", mem_a[400], 64'd0);
        chk("oor_mem510", mem_a[510], 64'd0);

        // All tokens out of range
        run_a(1'b0, {8'd255, 8'd250, 8'd201, 8'd200}, '0, 0, 20);
        chk("allskip_done_cyc", ra_done, 1);
        chk("allskip_traffic", ra_nre + ra_nwe, 0);
        chk("allskip_skip", ifa.skip_cnt, 4);

        // Saturation, lanes 0..3: +32760/+100, -32760/-100, +100/-300, -5/+3
        fill_mem_a({16'hFFFB, 16'h0064, 16'h8008, 16'h7FF8});
        run_a(1'b0, {8'd40, 8'd30, 8'd20, 8'd10}, {8{64'h0003_FED4_FF9C_0064}}, 0, 40);
        chk("sat_mem21", mem_a[21], {16'hFFFE, 16'hFF38, 16'h8000, 16'h7FFF});
        chk("sat_mem80", mem_a[80], {16'hFFFE, 16'hFF38, 16'h8000, 16'h7FFF});
        chk("sat_untouched", mem_a[22], {16'hFFFB, 16'h0064, 16'h8008, 16'h7FF8});

        // Repeated row with WPR=2 (forwarding at distance 2), grads 1..4
        fill_mem_a(64'd0);
        for (int t = 0; t < 4; t++) for (int j = 0; j < 8; j++)
            bwd_a[(t*8+j)*16 +: 16] = 16'(t + 1);
        run_a(1'b0, {8'd9, 8'd9, 8'd9, 8'd9}, bwd_a, 0, 40);
        chk("rep2_done_cyc", ra_done, 11);
        chk("rep2_mem18", mem_a[18], rep(16'd10));
        chk("rep2_mem19", mem_a[19], rep(16'd10));

        // Repeated row with WPR=1 (forwarding at distances 1 and 2)
        fill_mem_b(64'd0);
        run_b({8'd5, 8'd5, 8'd5, 8'd5}, {16{16'd1}}, 40);
        chk("rep1_done_cyc", rb_done, 7);
        chk("rep1_nwe", rb_nwe, 4);
        chk("rep1_mem5", mem_b[5], rep(16'd4));
        fill_mem_b(64'd0);
        for (int t = 0; t < 4; t++) for (int j = 0; j < 4; j++)
            bwd_b[(t*4+j)*16 +: 16] = 16'(t + 1);
        run_b({8'd5, 8'd5, 8'd6, 8'd5}, bwd_b, 40);
        chk("rep1b_mem5", mem_b[5], rep(16'd8));
        chk("rep1b_mem6", mem_b[6], rep(16'd2));

        // Clear mode
        fill_mem_a(rep(16'd7));
        run_a(1'b1, FWD_DIST, '0, 0, 500);
        chk("clr_done_cyc", ra_done, 401);
        chk("clr_nwe", ra_nwe, 400);
        chk("clr_nre", ra_nre, 0);
        chk("clr_seq", ra_seq_bad, 0);
        chk("clr_mem0", mem_a[0], 64'd0);
        chk("clr_mem399", mem_a[399], 64'd0);
        chk("clr_mem400", mem_a[400], rep(16'd7));

        // start while busy is ignored
        fill_mem_a(64'd0);
        run_a(1'b0, FWD_DIST, {32{16'd2}}, 3, 40);
        chk("busy_start_ndone", ra_ndone, 1);
        chk("busy_start_nre", ra_nre, 8);
        chk("busy_start_done_cyc", ra_done, 11);
        chk("busy_start_mem6", mem_a[6], rep(16'd2));

        // Reset in cycle 4 of an accumulate
        @(negedge clk);
        ifa.start = 1'b1; ifa.mode = 1'b0; ifa.d_forward = FWD_DIST; ifa.d_backward = {32{16'd2}};
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_ctl", {ifa.busy, ifa.done, ifa.re, ifa.we}, 0);
        chk("midrst_raddr", ifa.raddr, 0);
        chk("midrst_waddr", ifa.waddr, 0);
        chk("midrst_wdata", ifa.wdata, 0);
        chk("midrst_skip", ifa.skip_cnt, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (ifa.we) cnt++;
        end
        chk("midrst_no_we", cnt, 0);
        fill_mem_a(rep(16'd1));
        run_a(1'b0, FWD_DIST, {32{16'd2}}, 0, 40);
        chk("after_rst_done_cyc", ra_done, 11);
        chk("after_rst_mem15", mem_a[15], rep(16'd3));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/emb_grad_accum.md
# emb_grad_accum

Parametrised embedding-gradient accumulator for the training path. It scatters a batch of per-token gradient rows into the embedding weight-gradient RAM by read-modify-write, one RAM word per cycle. On top of the fixed-size accumulator it adds a start/busy/done handshake, explicit RAM enables, in-flight hazard forwarding for repeated indices, saturating arithmetic, out-of-range index skipping and a clear mode. It sits between the embedding backward data path and the gradient RAM (synchronous read, 1-cycle latency, read-before-write on same-address collision).

## Interface
- TOKENS, 10, tokens per batch
- CHAR_NUM, 200, embedding table rows
- CHAR_W, 8, index width
- EMB_DIM, 24, embedding width; must be a multiple of LANES
- LANES, 8, values per RAM word
- GRAD_W, 16, signed input gradient lane width; GRAD_W <= ACC_W
- ACC_W, 16, signed accumulator lane width
- ADDR_WIDTH, 10, RAM address width; must be >= clog2(CHAR_NUM*EMB_DIM/LANES)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only when idle
- mode  in  1  sampled with start: 0 = accumulate, 1 = clear
- d_forward  in  TOKENS*CHAR_W  token indices, token t at [t*CHAR_W +: CHAR_W]
- d_backward  in  TOKENS*EMB_DIM*GRAD_W  gradients, lane j of token t at [(t*EMB_DIM+j)*GRAD_W +: GRAD_W]
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- skip_cnt  out  CHAR_W  tokens skipped in the last operation
- re  out  1  RAM read enable
- raddr  out  ADDR_WIDTH  RAM read address
- rdata  in  LANES*ACC_W  RAM read data, valid the cycle after re
- we  out  1  RAM write enable
- waddr  out  ADDR_WIDTH  RAM write address
- wdata  out  LANES*ACC_W  RAM write data

## Operation
- WPR = EMB_DIM/LANES words per row. Token t word k maps to address idx_t*WPR + k.
- States: IDLE, ACC, CLEAR, DRAIN.
- IDLE:
  - start=1 latches d_forward, d_backward and mode.
  - Clears skip_cnt.
  - Goes to ACC (mode 0) or CLEAR (mode 1).
  - Inputs may change after the start cycle.
- ACC:
  - Issues one read per cycle, token-major then word order.
  - A token with idx >= CHAR_NUM issues no reads or writes, costs zero cycles and increments skip_cnt.
  - After the last issue, goes to DRAIN.
  - If every token is skipped, goes straight to DRAIN.
- Pipeline: issue (re/raddr) in cycle c, rdata arrives in c+1, sum is registered, write (we/waddr/wdata) happens in c+2.
- Per-lane arithmetic:
  - Sign-extend the gradient to ACC_W.
  - Add in ACC_W+1 bits.
  - Saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Forwarding, for repeated indices when WPR <= 2:
  - When rdata for address A arrives, the base operand is the youngest of the two previous operations whose write address equals A.
  - Only if neither matches is rdata used.
  - Result must equal sequential accumulation.
- CLEAR:
  - Writes zero to addresses 0 .. CHAR_NUM*WPR-1, one per cycle.
  - re=0 throughout.
  - Then goes to DRAIN.
- DRAIN: waits until all writes have completed, pulses done, returns to IDLE.
- start while not IDLE is ignored.
- Reset:
  - Reset values: busy, done, re, we, raddr, waddr, wdata, skip_cnt = 0.
  - State goes to IDLE.
  - Reset mid-operation discards in-flight writes; no we is issued after reset deasserts.

## Timing
- start accepted at edge 0:
  - busy=1 from cycle 1.
  - First re/raddr in cycle 1.
- Accumulate, with R = issued reads:
  - Reads in cycles 1..R.
  - Writes in cycles 3..R+2.
  - done=1 in cycle R+3, with busy=0 in the same cycle.
  - Back-to-back start is allowed in cycle R+3.
- R=0 (all skipped): done in cycle 1, no RAM traffic.
- Clear: writes in cycles 1..D with D = CHAR_NUM*WPR; done in cycle D+1.
- Throughput: one word per cycle, with no bubbles for forwarding or token boundaries.
- re and we are single-cycle qualified.
- raddr, waddr and wdata are don't-care when their enable is low, but are held at 0 after reset.

## Test plan
- Distinct indices, TOKENS=4, EMB_DIM=8, LANES=4 (WPR=2), idx={3,7,0,5}, RAM preloaded with 1, all grads 2:
  - Addresses 6,7,14,15,0,1,10,11 become 3.
  - done at cycle 11.
- Repeated index, WPR=1, idx={5,5,5,5}, RAM[5]=0, grad 1 per lane: RAM[5] = 4 per lane (forwarding at distances 1 and 2).
- Saturation:
  - RAM=32760 with grad 100 gives 32767.
  - RAM=-32760 with grad -100 gives -32768.
  - Mixed-sign lanes within one word stay independent.
- Out-of-range, CHAR_NUM=200, idx={199,200,255,0}:
  - Only rows 199 and 0 are written.
  - skip_cnt=2.
  - done at cycle 2*WPR+3.
- Clear, mode=1, CHAR_NUM=200, WPR=3:
  - 600 zero writes at addresses 0..599.
  - re never high.
  - done at cycle 601.
- Control:
  - start pulsed during busy is ignored: exactly one done per accepted start.
  - rst asserted at cycle 4 of an accumulate:
    - All outputs 0 immediately.
    - No we after release.
    - A new start runs cleanly.
